regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register data width in bits.
REQ-002 The block SHALL have parameter NREG, default 15, giving the number of registers, with legal values 1..15.
REQ-003 The block SHALL have parameter BYPASS, default 1, where 1 means read ports see same-edge writes (write-through) and 0 means they see pre-write contents.

Ports (name  direction  width  meaning):
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous active-low reset (reset=0 resets immediately, independent of clock).
REQ-006 dstE  in  4  write-port-E register ID; ID >= NREG (incl. 4'hF) = no write.
REQ-007 valE  in  DATA_W  write-port-E data.
REQ-008 dstM  in  4  write-port-M register ID; ID >= NREG = no write.
REQ-009 valM  in  DATA_W  write-port-M data.
REQ-010 srcA  in  4  read-port-A register ID.
REQ-011 srcB  in  4  read-port-B register ID.
REQ-012 rID  in  4  debug-read register ID.
REQ-013 clear  in  1  single-cycle request to start a sequential scrub of all registers.
REQ-014 valA  out  DATA_W  registered read data, port A.
REQ-015 valB  out  DATA_W  registered read data, port B.
REQ-016 rdata  out  DATA_W  registered debug read data.
REQ-017 regs_flat  out  NREG*DATA_W  current contents of all registers; reg[i] at bits [i*DATA_W +: DATA_W]; not an extra register stage.
REQ-018 busy  out  1  high while a scrub is in progress; registered.

Function
REQ-019 On each rising edge, reg[dstE] <= valE if dstE < NREG, and reg[dstM] <= valM if dstM < NREG.
REQ-020 When dstE == dstM < NREG, valM SHALL win, so reg receives valM.
REQ-021 valA, valB and rdata SHALL update on every rising edge with 1-cycle latency: the value captured at edge k is from reg[src] sampled at edge k.
REQ-022 With BYPASS=1, a read whose ID matches a write (or scrub) on the same edge SHALL return the newly written value, with priority scrub > M > E; with BYPASS=0 it SHALL return the pre-edge value.
REQ-023 A read ID >= NREG SHALL return 0 on the next edge, not hold the previous value.
REQ-024 The scrub FSM SHALL have two states, IDLE and SCRUB, with index counter idx of width ceil(log2(NREG)) (minimum 1).
REQ-025 In IDLE, clear=1 at an edge SHALL move to SCRUB with idx=0 and busy=1; clear=0 stays in IDLE.
REQ-026 At each edge in SCRUB, reg[idx] <= 0 and idx <= idx+1; at the edge where idx == NREG-1, the FSM SHALL return to IDLE with busy=0, so busy is high for exactly NREG cycles.
REQ-027 During SCRUB, a write port targeting reg[idx] on that edge SHALL be discarded (scrub wins), and writes to other registers SHALL proceed normally, including writes to already-scrubbed registers.
REQ-028 clear asserted during SCRUB SHALL be ignored, with no restart and no extension.
REQ-029 Reads SHALL stay fully operational during SCRUB.
REQ-030 There SHALL be no stall or back-pressure on any port; writes are never refused except under REQ-027.

Reset
REQ-031 While reset=0, all registers, valA, valB, rdata and busy SHALL be 0, idx SHALL be 0 and the FSM SHALL be IDLE, asynchronously.
REQ-032 Reset asserted mid-scrub SHALL abort the scrub immediately, and no scrub SHALL resume after reset release.
REQ-033 After reset release, the first edge SHALL already accept writes and clear.

Verification
REQ-034 Reset, then dstE=2/valE=0x11 with dstM=15, then srcA=2 -> after the write edge reg2=0x11; valA=0x11 one edge after srcA=2 is applied; with BYPASS=1 and srcA=2 on the write edge, valA=0x11 on that same edge.
REQ-035 dstE=dstM=4, valE=0xAAAA, valM=0x5555 -> reg4=0x5555; with BYPASS=0 and srcB=4 on that edge, valB equals the old reg4, and the following edge gives 0x5555.
REQ-036 Preload all regs with 0xFF, pulse clear -> busy high exactly NREG (15) cycles; reg[i] reads 0 from edge i+1; clear re-pulsed at cycle 3 has no effect.
REQ-037 During scrub at idx=5, dstM=5/valM=0x77 and dstE=1/valE=0x99 -> reg5=0, reg1=0x99 (already scrubbed, kept).
REQ-038 Assert reset=0 asynchronously between edges mid-scrub -> all outputs 0 before the next edge; busy=0; reg writes after release are retained.
REQ-039 srcA=14 with NREG=8, rID=15 after valA/rdata held nonzero -> both read 0 one edge later; dstE=9 writes nothing (regs_flat unchanged).

Source files
------------

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - register file port bundle: two write ports, two read ports, debug read, scrub control
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int NREG   = 15
);
    logic [3:0]             dstE;
    logic [DATA_W-1:0]      valE;
    logic [3:0]             dstM;
    logic [DATA_W-1:0]      valM;
    logic [3:0]             srcA;
    logic [3:0]             srcB;
    logic [3:0]             rID;
    logic                   clear;
    logic [DATA_W-1:0]      valA;
    logic [DATA_W-1:0]      valB;
    logic [DATA_W-1:0]      rdata;
    logic [NREG*DATA_W-1:0] regs_flat;
    logic                   busy;

    modport master (
        output dstE, valE, dstM, valM, srcA, srcB, rID, clear,
        input  valA, valB, rdata, regs_flat, busy
    );

    modport slave (
        input  dstE, valE, dstM, valM, srcA, srcB, rID, clear,
        output valA, valB, rdata, regs_flat, busy
    );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with registered reads, optional write bypass and sequential scrub
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int NREG   = 15,
    parameter int BYPASS = 1
) (
    input  logic         clock,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic [DATA_W-1:0]  regs_q [NREG];
    logic [DATA_W-1:0]  regs_d [NREG];
    logic [DATA_W-1:0]  val_a_q, val_a_d;
    logic [DATA_W-1:0]  val_b_q, val_b_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    // Next register contents: E first, then M overrides, then the scrub slot overrides both.
    // IDs >= NREG never match a loop index, so they fall through as no-writes.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREG; i++) begin
            if (bus.dstE == 4'(i)) regs_d[i] = bus.valE;
            if (bus.dstM == 4'(i)) regs_d[i] = bus.valM;
            if ((state_q == SCRUB) && (idx_q == IDX_W'(i))) regs_d[i] = '0;
        end
    end

    // Read mux: write-through view (regs_d) or pre-edge view (regs_q); out-of-range IDs read 0.
    always_comb begin
        val_a_d = '0;
        val_b_d = '0;
        rdata_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (bus.srcA == 4'(i)) val_a_d = (BYPASS != 0) ? regs_d[i] : regs_q[i];
            if (bus.srcB == 4'(i)) val_b_d = (BYPASS != 0) ? regs_d[i] : regs_q[i];
            if (bus.rID  == 4'(i)) rdata_d = (BYPASS != 0) ? regs_d[i] : regs_q[i];
        end
    end

    // Scrub FSM: clear starts a walk over idx 0..NREG-1; clear is ignored while walking.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    state_d = SCRUB;
                    idx_d   = '0;
                end
            end
            SCRUB: begin
                if (idx_q == IDX_W'(NREG - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        busy_d = (state_d == SCRUB);
    end

    // State, register array and read-data flops; reset clears everything and aborts any scrub.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            val_a_q <= '0;
            val_b_q <= '0;
            rdata_q <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            val_a_q <= val_a_d;
            val_b_q <= val_b_d;
            rdata_q <= rdata_d;
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign bus.valA  = val_a_q;
    assign bus.valB  = val_b_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign bus.regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized and directed checks of regfile_mp against an array-based reference model
module tb_regfile_mp;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  dst_e = 4'hF, dst_m = 4'hF, src_a = 4'h0, src_b = 4'h0, r_id = 4'h0;
    logic [31:0] val_e = '0, val_m = '0;
    logic        clear_i = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    regfile_mp_if #(.DATA_W(32), .NREG(15)) if0 ();
    regfile_mp_if #(.DATA_W(32), .NREG(15)) if1 ();
    regfile_mp_if #(.DATA_W(32), .NREG(8))  if2 ();

    assign if0.dstE = dst_e; assign if0.valE = val_e; assign if0.dstM = dst_m; assign if0.valM = val_m;
    assign if0.srcA = src_a; assign if0.srcB = src_b; assign if0.rID = r_id;  assign if0.clear = clear_i;
    assign if1.dstE = dst_e; assign if1.valE = val_e; assign if1.dstM = dst_m; assign if1.valM = val_m;
    assign if1.srcA = src_a; assign if1.srcB = src_b; assign if1.rID = r_id;  assign if1.clear = clear_i;
    assign if2.dstE = dst_e; assign if2.valE = val_e; assign if2.dstM = dst_m; assign if2.valM = val_m;
    assign if2.srcA = src_a; assign if2.srcB = src_b; assign if2.rID = r_id;  assign if2.clear = clear_i;

    regfile_mp #(.DATA_W(32), .NREG(15), .BYPASS(1)) u0 (.clock(clock), .reset(reset), .bus(if0.slave));
    regfile_mp #(.DATA_W(32), .NREG(15), .BYPASS(0)) u1 (.clock(clock), .reset(reset), .bus(if1.slave));
    regfile_mp #(.DATA_W(32), .NREG(8),  .BYPASS(1)) u2 (.clock(clock), .reset(reset), .bus(if2.slave));

    // Reference model: plain arrays, scrub tracked as "next register to wipe" (-1 = none).
    localparam int NR [3] = '{15, 15, 8};
    localparam int BY [3] = '{1, 0, 1};
    logic [31:0] m_reg [3][16];
    int          m_pos [3];
    logic [31:0] m_a [3], m_b [3], m_r [3];

    task automatic m_reset();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) m_reg[d][i] = '0;
            m_pos[d] = -1;
            m_a[d] = '0; m_b[d] = '0; m_r[d] = '0;
        end
    endtask

    function automatic logic [31:0] m_read(int d, int id, logic [31:0] nw [16]);
        if (id >= NR[d]) return 32'h0;
        return (BY[d] != 0) ? nw[id] : m_reg[d][id];
    endfunction

    task automatic model_step();
        logic [31:0] nw [16];
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) nw[i] = m_reg[d][i];
            if (int'(dst_e) < NR[d]) nw[dst_e] = val_e;
            if (int'(dst_m) < NR[d]) nw[dst_m] = val_m;
            if (m_pos[d] >= 0) nw[m_pos[d]] = 32'h0;
            m_a[d] = m_read(d, int'(src_a), nw);
            m_b[d] = m_read(d, int'(src_b), nw);
            m_r[d] = m_read(d, int'(r_id), nw);
            if (m_pos[d] >= 0) begin
                m_pos[d]++;
                if (m_pos[d] == NR[d]) m_pos[d] = -1;
            end else if (clear_i) begin
                m_pos[d] = 0;
            end
            for (int i = 0; i < 16; i++) m_reg[d][i] = nw[i];
        end
    endtask

    function automatic logic [511:0] m_flat(int d);
        logic [511:0] f = '0;
        for (int i = 0; i < NR[d]; i++) f[i*32 +: 32] = m_reg[d][i];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all();
        chk("u0.valA", 512'(if0.valA), 512'(m_a[0]));
        chk("u0.valB", 512'(if0.valB), 512'(m_b[0]));
        chk("u0.rdata", 512'(if0.rdata), 512'(m_r[0]));
        chk("u0.busy", 512'(if0.busy), 512'(m_pos[0] >= 0));
        chk("u0.regs", 512'(if0.regs_flat), m_flat(0));
        chk("u1.valA", 512'(if1.valA), 512'(m_a[1]));
        chk("u1.valB", 512'(if1.valB), 512'(m_b[1]));
        chk("u1.rdata", 512'(if1.rdata), 512'(m_r[1]));
        chk("u1.busy", 512'(if1.busy), 512'(m_pos[1] >= 0));
        chk("u1.regs", 512'(if1.regs_flat), m_flat(1));
        chk("u2.valA", 512'(if2.valA), 512'(m_a[2]));
        chk("u2.valB", 512'(if2.valB), 512'(m_b[2]));
        chk("u2.rdata", 512'(if2.rdata), 512'(m_r[2]));
        chk("u2.busy", 512'(if2.busy), 512'(m_pos[2] >= 0));
        chk("u2.regs", 512'(if2.regs_flat), m_flat(2));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        @(negedge clock);
        chk_all();
    endtask

    task automatic idle_in();
        dst_e = 4'hF; dst_m = 4'hF; clear_i = 1'b0;
    endtask

    int cnt0, cnt2;

    initial begin
        m_reset();
        #12;
        chk_all();
        @(negedge clock);
        reset = 1'b1;

        // single write, bypass vs registered read
        dst_e = 4'd2; val_e = 32'h11; dst_m = 4'hF; src_a = 4'd2;
        cycle();
        chk("r034_bypass", 512'(if0.valA), 512'(32'h11));
        chk("r034_reg2", 512'(if0.regs_flat[95:64]), 512'(32'h11));
        idle_in();
        cycle();
        chk("r034_nobypass", 512'(if1.valA), 512'(32'h11));

        // same-register collision, M wins; BYPASS=0 sees old value first
        dst_e = 4'd4; val_e = 32'h1234;
        cycle();
        dst_e = 4'd4; val_e = 32'hAAAA; dst_m = 4'd4; val_m = 32'h5555; src_b = 4'd4;
        cycle();
        chk("r035_old", 512'(if1.valB), 512'(32'h1234));
        chk("r035_reg4", 512'(if0.regs_flat[159:128]), 512'(32'h5555));
        idle_in();
        cycle();
        chk("r035_new", 512'(if1.valB), 512'(32'h5555));

        // out-of-range reads return 0; out-of-range write ignored on NREG=8
        dst_e = 4'd3; val_e = 32'hC3;
        cycle();
        idle_in(); src_a = 4'd3; r_id = 4'd3;
        cycle();
        src_a = 4'd14; r_id = 4'd15; dst_e = 4'd9; val_e = 32'hDEAD;
        cycle();
        chk("r039_valA", 512'(if2.valA), 512'(32'h0));
        chk("r039_rdata", 512'(if2.rdata), 512'(32'h0));
        idle_in();

        // preload, scrub with a re-pulse of clear and a colliding write at idx 5
        for (int i = 0; i < 15; i++) begin
            dst_e = 4'(i); val_e = 32'hFF;
            cycle();
        end
        idle_in(); clear_i = 1'b1;
        cycle();
        cnt0 = int'(if0.busy); cnt2 = int'(if2.busy);
        for (int c = 0; c < 25; c++) begin
            idle_in();
            if (c == 3) clear_i = 1'b1;
            if (c == 5) begin
                dst_m = 4'd5; val_m = 32'h77; dst_e = 4'd1; val_e = 32'h99;
            end
            cycle();
            if (c == 5) begin
                chk("r037_reg5", 512'(if0.regs_flat[191:160]), 512'(32'h0));
                chk("r037_reg1", 512'(if0.regs_flat[63:32]), 512'(32'h99));
            end
            cnt0 += int'(if0.busy); cnt2 += int'(if2.busy);
        end
        chk("r036_busy15", 512'(cnt0), 512'(15));
        chk("r036_busy8", 512'(cnt2), 512'(8));
        idle_in();

        // asynchronous reset mid-scrub
        for (int i = 0; i < 8; i++) begin
            dst_e = 4'(i); val_e = 32'hA0 + 32'(i); src_a = 4'(i); src_b = 4'(i); r_id = 4'(i);
            cycle();
        end
        idle_in(); clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("r038_valA", 512'(if0.valA), 512'(32'h0));
        chk("r038_rdata", 512'(if0.rdata), 512'(32'h0));
        chk("r038_busy", 512'(if0.busy), 512'(1'b0));
        chk("r038_regs", 512'(if0.regs_flat), 512'(0));
        m_reset();
        chk_all();
        @(negedge clock);
        reset = 1'b1;
        dst_e = 4'd7; val_e = 32'hBEEF; src_a = 4'd7;
        cycle();
        idle_in();
        for (int i = 0; i < 3; i++) cycle();
        chk("r038_kept", 512'(if0.regs_flat[255:224]), 512'(32'hBEEF));

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            dst_e   = 4'($urandom_range(0, 15));
            dst_m   = 4'($urandom_range(0, 15));
            val_e   = $urandom;
            val_m   = $urandom;
            src_a   = 4'($urandom_range(0, 15));
            src_b   = 4'($urandom_range(0, 15));
            r_id    = 4'($urandom_range(0, 15));
            clear_i = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
